// File: rtl/alu_reg_controller.sv
// Control sequencer for the register-file ALU datapath: accepts one instruction over
// valid/ready, drives in_sel/reg_addr/alu_sel per cycle and samples the datapath carry.
module alu_reg_controller #(
  parameter int unsigned BIT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           instr_op,
  input  logic [BIT_WIDTH-1:0] instr_data,
  output logic [BIT_WIDTH-1:0] dp_in,
  output logic                 dp_s_reg,
  output logic [1:0]           dp_reg_addr,
  output logic                 dp_s,
  input  logic                 dp_cout,
  output logic                 c_flag,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 2;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDA  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LDB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SUBI = OP_W'(6);
  localparam logic [OP_W-1:0] OP_OUT  = OP_W'(7);

  localparam logic [ADDR_W-1:0] ADDR_A    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_B    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_O    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_NONE = ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADB = 2'd1,
    EXEC  = 2'd2,
    CARRY = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic                 c_flag_q, c_flag_d;
  logic                 is_alu;
  logic                 is_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      c_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      c_flag_q <= c_flag_d;
    end
  end

  // Next state plus the per-cycle datapath control decode of state and latched op
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    c_flag_d    = c_flag_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    dp_in       = '0;
    dp_s_reg    = 1'b0;
    dp_reg_addr = ADDR_NONE;
    dp_s        = 1'b0;
    is_alu      = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                  (op_q == OP_ADDI) || (op_q == OP_SUBI);
    is_sub      = (op_q == OP_SUB) || (op_q == OP_SUBI);

    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          data_d  = instr_data;
          state_d = ((instr_op == OP_ADDI) || (instr_op == OP_SUBI)) ? LOADB : EXEC;
        end
      end
      LOADB: begin
        dp_reg_addr = ADDR_B;
        dp_s_reg    = 1'b1;
        dp_in       = data_q;
        state_d     = EXEC;
      end
      EXEC: begin
        unique case (op_q)
          OP_LDA: begin
            dp_reg_addr = ADDR_A;
            dp_s_reg    = 1'b1;
            dp_in       = data_q;
          end
          OP_LDB: begin
            dp_reg_addr = ADDR_B;
            dp_s_reg    = 1'b1;
            dp_in       = data_q;
          end
          OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
            dp_reg_addr = ADDR_A;
            dp_s        = is_sub;
          end
          OP_OUT:  dp_reg_addr = ADDR_O;
          default: dp_reg_addr = ADDR_NONE;
        endcase
        if (is_alu) begin
          state_d = CARRY;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      CARRY: begin
        // Carry was registered by the datapath on the EXEC write edge
        done     = 1'b1;
        c_flag_d = dp_cout;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = ~instr_ready;
  assign c_flag = c_flag_q;

endmodule
